// File: rtl/bootrom_loader.sv
// Boot-copy engine: reads WORDS words from the boot ROM over Wishbone, writes them
// to tile RAM, and releases the tile CPU from reset once the copy completes.
module bootrom_loader #(
    parameter logic [31:0] SRC_BASE = 32'h0000_0000,
    parameter logic [31:0] DST_BASE = 32'h0000_0000,
    parameter int unsigned WORDS    = 64,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,

    output logic [31:0] rom_adr_o,
    output logic        rom_cyc_o,
    output logic        rom_stb_o,
    output logic [3:0]  rom_sel_o,
    input  logic [31:0] rom_dat_i,
    input  logic        rom_ack_i,
    input  logic        rom_err_i,

    output logic [31:0] ram_adr_o,
    output logic [31:0] ram_dat_o,
    output logic        ram_cyc_o,
    output logic        ram_stb_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    input  logic        ram_ack_i,
    input  logic        ram_err_i,

    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] checksum_o
);

    localparam int unsigned    TMO_W    = $clog2(TIMEOUT + 2);
    localparam logic [15:0]    LAST_IDX = 16'(WORDS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam bit             TMO_EN   = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_idx;
    logic [31:0]       r_buf;
    logic [31:0]       r_sum;
    logic [TMO_W-1:0]  r_tmo;

    logic              w_last;
    logic              w_tmo_hit;
    logic              w_rom_take;
    logic              w_ram_take;

    assign w_last     = (r_idx == LAST_IDX);
    assign w_tmo_hit  = TMO_EN && (r_tmo == TMO_LAST);
    assign w_rom_take = (r_state == S_READ)  && rom_ack_i && !rom_err_i;
    assign w_ram_take = (r_state == S_WRITE) && ram_ack_i && !ram_err_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: err beats ack, ack beats timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = S_READ;
            S_READ: begin
                if (rom_err_i)      w_state_nxt = S_ERROR;
                else if (rom_ack_i) w_state_nxt = S_WRITE;
                else if (w_tmo_hit) w_state_nxt = S_ERROR;
            end
            S_WRITE: begin
                if (ram_err_i)      w_state_nxt = S_ERROR;
                else if (ram_ack_i) w_state_nxt = w_last ? S_DONE : S_READ;
                else if (w_tmo_hit) w_state_nxt = S_ERROR;
            end
            S_DONE:  w_state_nxt = S_DONE;
            S_ERROR: w_state_nxt = S_ERROR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: word index, data buffer, running checksum, stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_buf <= '0;
            r_sum <= '0;
            r_tmo <= '0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_tmo <= '0;
            end else if ((r_state == S_READ) || (r_state == S_WRITE)) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            if (w_rom_take) begin
                r_buf <= rom_dat_i;
                r_sum <= r_sum + rom_dat_i;
            end
            if (w_ram_take && !w_last) begin
                r_idx <= r_idx + 16'd1;
            end
        end
    end

    // Bus and status outputs decoded from the registered state
    always_comb begin
        rom_cyc_o = 1'b0;
        rom_stb_o = 1'b0;
        ram_cyc_o = 1'b0;
        ram_stb_o = 1'b0;
        ram_we_o  = 1'b0;
        cpu_rst_o = 1'b1;
        done_o    = 1'b0;
        error_o   = 1'b0;
        case (r_state)
            S_READ: begin
                rom_cyc_o = 1'b1;
                rom_stb_o = 1'b1;
            end
            S_WRITE: begin
                ram_cyc_o = 1'b1;
                ram_stb_o = 1'b1;
                ram_we_o  = 1'b1;
            end
            S_DONE: begin
                done_o    = 1'b1;
                cpu_rst_o = 1'b0;
            end
            S_ERROR: begin
                error_o   = 1'b1;
            end
            default: ;
        endcase
    end

    assign rom_adr_o  = SRC_BASE + {14'd0, r_idx, 2'b00};
    assign ram_adr_o  = DST_BASE + {14'd0, r_idx, 2'b00};
    assign ram_dat_o  = r_buf;
    assign rom_sel_o  = 4'hF;
    assign ram_sel_o  = 4'hF;
    assign checksum_o = r_sum;

endmodule
